pdm_cic_rx: RTL and testbench

PDM_CIC_RX -- requirements
Module: pdm_cic_rx

---
 rtl/pdm_cic_rx.sv | 209 ++++++++++++++++++++
 tb/tb_pdm_cic_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_rx.sv
// rtl/pdm_cic_rx.sv - stereo PDM receiver with third-order CIC decimator
//
// Purpose: decodes a stereo PDM bitstream (left channel at ock rise, right at
// ock fall) into two 16-bit PCM streams, one sample pair per uck rise.
// Integrators run on synchronized ock edges; a small FSM runs the three comb
// stages serially, then saturates and left-justifies the result.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-high reset
//   sdi          PDM data (asynchronous, synchronized internally)
//   ock          oversample clock (asynchronous, sampled as data)
//   uck          output-rate clock (asynchronous, sampled as data)
//   enable       block enable; low clears filter state, dout holds
//   signed_data  1 = two's complement output, 0 = offset binary
//   dout_l       left PCM sample, 16 bits left-justified in 32
//   dout_r       right PCM sample, 16 bits left-justified in 32
//   valid        one-clk pulse when dout_l/dout_r update
//   ovf          one-clk pulse when a uck rise is dropped (comb busy)
module pdm_cic_rx #(
  parameter int ORDER = 3,
  parameter int DECIM = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdi,
  input  logic        ock,
  input  logic        uck,
  input  logic        enable,
  input  logic        signed_data,
  output logic [31:0] dout_l,
  output logic [31:0] dout_r,
  output logic        valid,
  output logic        ovf
);

  localparam int W = 2 + ORDER * $clog2(DECIM);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_C1   = 3'd1;
  localparam logic [2:0] ST_C2   = 3'd2;
  localparam logic [2:0] ST_C3   = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  // synchronizers and edge-detect registers
  logic sdi_s1_q, sdi_s1_d, sdi_s2_q, sdi_s2_d;
  logic ock_s1_q, ock_s1_d, ock_s2_q, ock_s2_d, ock_p_q, ock_p_d;
  logic uck_s1_q, uck_s1_d, uck_s2_q, uck_s2_d, uck_p_q, uck_p_d;
  logic [1:0] arm_q, arm_d;

  // integrator chains
  logic [W-1:0] il1_q, il1_d, il2_q, il2_d, il3_q, il3_d;
  logic [W-1:0] ir1_q, ir1_d, ir2_q, ir2_d, ir3_q, ir3_d;

  // comb working value and delay registers
  logic [W-1:0] wl_q, wl_d, wr_q, wr_d;
  logic [W-1:0] cl1_q, cl1_d, cl2_q, cl2_d, cl3_q, cl3_d;
  logic [W-1:0] cr1_q, cr1_d, cr2_q, cr2_d, cr3_q, cr3_d;

  logic [2:0]  state_q, state_d;
  logic [31:0] dout_l_q, dout_l_d, dout_r_q, dout_r_d;
  logic        valid_q, valid_d, ovf_q, ovf_d;

  logic         armed, ock_rise, ock_fall, uck_rise;
  logic [W-1:0] x;

  // Saturate a W-bit comb result to 16 bits and left-justify; in offset
  // binary mode only the sign bit flips.
  function automatic logic [31:0] pack(input logic [W-1:0] v, input logic sd);
    logic [15:0] s;
    if (v[W-1:15] == {(W-15){v[W-1]}}) s = v[15:0];
    else                               s = v[W-1] ? 16'h8000 : 16'h7fff;
    return {s[15] ^ ~sd, s[14:0], 16'h0000};
  endfunction

  always_comb begin
    sdi_s1_d = sdi;
    sdi_s2_d = sdi_s1_q;
    ock_s1_d = ock;
    ock_s2_d = ock_s1_q;
    ock_p_d  = ock_s2_q;
    uck_s1_d = uck;
    uck_s2_d = uck_s1_q;
    uck_p_d  = uck_s2_q;
    // Edges are only trusted once the previous-level register holds a real
    // synchronized sample, so the level seen right after reset is no edge.
    arm_d    = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    armed    = (arm_q == 2'd3);

    ock_rise = armed &  ock_s2_q & ~ock_p_q;
    ock_fall = armed & ~ock_s2_q &  ock_p_q;
    uck_rise = armed &  uck_s2_q & ~uck_p_q;

    // sdi 1 -> +1, sdi 0 -> -1
    x = {{(W-1){~sdi_s2_q}}, 1'b1};

    il1_d = il1_q;  il2_d = il2_q;  il3_d = il3_q;
    ir1_d = ir1_q;  ir2_d = ir2_q;  ir3_d = ir3_q;
    wl_d  = wl_q;   wr_d  = wr_q;
    cl1_d = cl1_q;  cl2_d = cl2_q;  cl3_d = cl3_q;
    cr1_d = cr1_q;  cr2_d = cr2_q;  cr3_d = cr3_q;
    state_d  = state_q;
    dout_l_d = dout_l_q;
    dout_r_d = dout_r_q;
    valid_d  = enable && (state_q == ST_OUT);
    ovf_d    = enable && uck_rise && (state_q != ST_IDLE);

    // each stage consumes the value just produced by the stage before it
    if (ock_rise) begin
      il1_d = il1_q + x;
      il2_d = il2_q + il1_d;
      il3_d = il3_q + il2_d;
    end
    if (ock_fall) begin
      ir1_d = ir1_q + x;
      ir2_d = ir2_q + ir1_d;
      ir3_d = ir3_q + ir2_d;
    end

    case (state_q)
      ST_IDLE: begin
        if (uck_rise) begin
          // snapshot includes an integrator update landing in this cycle
          wl_d    = il3_d;
          wr_d    = ir3_d;
          state_d = ST_C1;
        end
      end
      ST_C1: begin
        wl_d    = wl_q - cl1_q;
        cl1_d   = wl_q;
        wr_d    = wr_q - cr1_q;
        cr1_d   = wr_q;
        state_d = ST_C2;
      end
      ST_C2: begin
        wl_d    = wl_q - cl2_q;
        cl2_d   = wl_q;
        wr_d    = wr_q - cr2_q;
        cr2_d   = wr_q;
        state_d = ST_C3;
      end
      ST_C3: begin
        wl_d    = wl_q - cl3_q;
        cl3_d   = wl_q;
        wr_d    = wr_q - cr3_q;
        cr3_d   = wr_q;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        dout_l_d = pack(wl_q, signed_data);
        dout_r_d = pack(wr_q, signed_data);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      il1_d = '0;  il2_d = '0;  il3_d = '0;
      ir1_d = '0;  ir2_d = '0;  ir3_d = '0;
      wl_d  = '0;  wr_d  = '0;
      cl1_d = '0;  cl2_d = '0;  cl3_d = '0;
      cr1_d = '0;  cr2_d = '0;  cr3_d = '0;
      state_d  = ST_IDLE;
      dout_l_d = dout_l_q;
      dout_r_d = dout_r_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdi_s1_q <= 1'b0;  sdi_s2_q <= 1'b0;
      ock_s1_q <= 1'b0;  ock_s2_q <= 1'b0;  ock_p_q <= 1'b0;
      uck_s1_q <= 1'b0;  uck_s2_q <= 1'b0;  uck_p_q <= 1'b0;
      arm_q    <= '0;
      il1_q <= '0;  il2_q <= '0;  il3_q <= '0;
      ir1_q <= '0;  ir2_q <= '0;  ir3_q <= '0;
      wl_q  <= '0;  wr_q  <= '0;
      cl1_q <= '0;  cl2_q <= '0;  cl3_q <= '0;
      cr1_q <= '0;  cr2_q <= '0;  cr3_q <= '0;
      state_q  <= ST_IDLE;
      dout_l_q <= '0;
      dout_r_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sdi_s1_q <= sdi_s1_d;  sdi_s2_q <= sdi_s2_d;
      ock_s1_q <= ock_s1_d;  ock_s2_q <= ock_s2_d;  ock_p_q <= ock_p_d;
      uck_s1_q <= uck_s1_d;  uck_s2_q <= uck_s2_d;  uck_p_q <= uck_p_d;
      arm_q    <= arm_d;
      il1_q <= il1_d;  il2_q <= il2_d;  il3_q <= il3_d;
      ir1_q <= ir1_d;  ir2_q <= ir2_d;  ir3_q <= ir3_d;
      wl_q  <= wl_d;   wr_q  <= wr_d;
      cl1_q <= cl1_d;  cl2_q <= cl2_d;  cl3_q <= cl3_d;
      cr1_q <= cr1_d;  cr2_q <= cr2_d;  cr3_q <= cr3_d;
      state_q  <= state_d;
      dout_l_q <= dout_l_d;
      dout_r_q <= dout_r_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dout_l = dout_l_q;
  assign dout_r = dout_r_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_pdm_cic_rx.sv
// tb/tb_pdm_cic_rx.sv - self-checking bench for pdm_cic_rx
module tb_pdm_cic_rx;

  logic        clk = 1'b0;
  logic        rst, sdi, ock, uck, enable, signed_data;
  logic [31:0] dout_l, dout_r;
  logic        valid, ovf;

  pdm_cic_rx #(.ORDER(3), .DECIM(32)) dut (
    .clk(clk), .rst(rst), .sdi(sdi), .ock(ock), .uck(uck),
    .enable(enable), .signed_data(signed_data),
    .dout_l(dout_l), .dout_r(dout_r), .valid(valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int iter; logic [31:0] l; logic [31:0] r; } exp_t;
  typedef struct { int mode; logic sd; logic [31:0] exp_l; logic [31:0] exp_r; string name; } vec_t;

  int checks = 0;
  int errors = 0;
  int k = 0;

  // reference model: raw +/-1 sample lists, sample counts at each accepted
  // snapshot, and the expected output/ovf events with their arrival step
  int   left_x[$], right_x[$], snap_l[$], snap_r[$];
  exp_t exp_q[$];
  int   ovf_q[$];
  int   last_acc;
  int   n_acc, n_valid, n_ovf, last_valid_iter, valid_gap;
  logic ock_prev, uck_prev;

  // stimulus generator
  logic g_ock, g_sdi, g_jit;
  int   g_rem, g_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (step %0d)", name, act, req, k);
    end
  endtask

  // triple running sum of the first n samples, in closed form
  function automatic longint s3(input bit right, input int n);
    longint acc = 0;
    for (int j = 0; j < n; j++) begin
      longint m = n - j;
      acc += (right ? right_x[j] : left_x[j]) * (m * (m + 1) / 2);
    end
    return acc;
  endfunction

  // third difference of the decimated triple sum, wrapped to 17 bits,
  // saturated to 16 bits and left-justified
  function automatic logic [31:0] cic_out(input bit right, input logic sd);
    int          sz, n, c, v;
    longint      y;
    logic [16:0] w;
    logic [31:0] d;
    sz = right ? snap_r.size() : snap_l.size();
    y  = 0;
    for (int i = 0; i < 4; i++) begin
      if (sz - 1 - i >= 0) begin
        n = right ? snap_r[sz-1-i] : snap_l[sz-1-i];
        c = (i == 0) ? 1 : (i == 1) ? -3 : (i == 2) ? 3 : -1;
        y += c * s3(right, n);
      end
    end
    w = y[16:0];
    v = $signed(w);
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    d = {v[15:0], 16'h0000};
    if (!sd) d[31] = ~d[31];
    return d;
  endfunction

  task automatic model_clear();
    left_x.delete(); right_x.delete(); snap_l.delete(); snap_r.delete();
    exp_q.delete(); ovf_q.delete();
    last_acc = -100;
  endtask

  task automatic clear_counts();
    n_acc = 0; n_valid = 0; n_ovf = 0; last_valid_iter = -1; valid_gap = 0;
  endtask

  task automatic sample_outputs();
    logic v_exp, o_exp;
    v_exp = (exp_q.size() > 0) && (exp_q[0].iter == k);
    checks++;
    if (valid !== v_exp) begin
      errors++;
      $display("FAIL valid_timing: got %b expected %b (step %0d)", valid, v_exp, k);
    end else if (v_exp) begin
      check("dout_l", dout_l, exp_q[0].l);
      check("dout_r", dout_r, exp_q[0].r);
      n_valid++;
      if (last_valid_iter >= 0) valid_gap = k - last_valid_iter;
      last_valid_iter = k;
    end
    if (v_exp) void'(exp_q.pop_front());
    o_exp = (ovf_q.size() > 0) && (ovf_q[0] == k);
    checks++;
    if (ovf !== o_exp) begin
      errors++;
      $display("FAIL ovf_timing: got %b expected %b (step %0d)", ovf, o_exp, k);
    end else if (o_exp) n_ovf++;
    if (o_exp) void'(ovf_q.pop_front());
  endtask

  // One clk step: sample outputs at the falling edge, then drive inputs and
  // advance the model. Outputs appear 7 steps (valid) or 3 steps (ovf) after
  // the step that drove the uck rise: 2 synchronizer stages + edge register,
  // then C1, C2, C3, OUT and the valid register.
  task automatic step(input logic o, input logic u, input logic s);
    @(negedge clk);
    k++;
    sample_outputs();
    if (!rst && enable) begin
      if (o && !ock_prev) left_x.push_back(s ? 1 : -1);
      if (!o && ock_prev) right_x.push_back(s ? 1 : -1);
      if (u && !uck_prev) begin
        if (k - last_acc <= 4) ovf_q.push_back(k + 3);
        else begin
          exp_t e;
          snap_l.push_back(left_x.size());
          snap_r.push_back(right_x.size());
          e.iter = k + 7;
          e.l = cic_out(1'b0, signed_data);
          e.r = cic_out(1'b1, signed_data);
          exp_q.push_back(e);
          last_acc = k;
          n_acc++;
        end
      end
    end
    ock_prev = o; uck_prev = u;
    ock = o; uck = u; sdi = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic gen_reset();
    g_ock = 1'b0; g_rem = 2; g_cnt = 0; g_sdi = 1'b0;
  endtask

  // modes: 0 all ones, 1 all zeros, 2 left ones/right zeros,
  //        3 left alternating/right ones, 4 random
  // uck = bit 4 of the ock-rise count: 32 ock periods per uck period
  task automatic gen_step(input int mode);
    if (g_rem == 0) begin
      g_ock = ~g_ock;
      g_rem = g_jit ? $urandom_range(3, 2) : 2;
      if (g_ock) g_cnt++;
      case (mode)
        0:       g_sdi = 1'b1;
        1:       g_sdi = 1'b0;
        2:       g_sdi = g_ock;
        3:       g_sdi = g_ock ? g_cnt[0] : 1'b1;
        default: g_sdi = 1'($urandom);
      endcase
    end
    g_rem--;
    step(g_ock, g_cnt[4], (mode == 4) ? 1'($urandom) : g_sdi);
  endtask

  task automatic run(input int mode, input int periods);
    int target = periods * 32 + 16;
    int i = 0;
    while (g_cnt < target && i < periods * 32 * 8 + 200) begin
      gen_step(mode);
      i++;
    end
    checks++;
    if (g_cnt < target) begin
      errors++;
      $display("FAIL run_budget: got %0d ock rises expected %0d", g_cnt, target);
    end
    idle(12);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    model_clear();
    idle(3);
    rst = 1'b0;
    idle(5);
    gen_reset();
    clear_counts();
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1'b1; enable = 1'b1; signed_data = 1'b1;
    sdi = 1'b0; ock = 1'b0; uck = 1'b0;
    ock_prev = 1'b0; uck_prev = 1'b0; g_jit = 1'b0;
    model_clear(); clear_counts(); gen_reset();

    repeat (2) @(negedge clk);
    check("reset_dout_l", dout_l, 32'h0);
    check("reset_dout_r", dout_r, 32'h0);
    check("reset_valid", {31'b0, valid}, 32'h0);
    check("reset_ovf", {31'b0, ovf}, 32'h0);

    vecs[0] = '{0, 1'b1, 32'h7FFF0000, 32'h7FFF0000, "ones_signed"};
    vecs[1] = '{1, 1'b1, 32'h80000000, 32'h80000000, "zeros_signed"};
    vecs[2] = '{1, 1'b0, 32'h00000000, 32'h00000000, "zeros_offset"};
    vecs[3] = '{0, 1'b0, 32'hFFFF0000, 32'hFFFF0000, "ones_offset"};
    vecs[4] = '{2, 1'b1, 32'h7FFF0000, 32'h80000000, "split_channels"};
    vecs[5] = '{3, 1'b1, 32'h00000000, 32'h7FFF0000, "left_alternating"};

    for (int v = 0; v < 6; v++) begin
      signed_data = vecs[v].sd;
      do_reset();
      run(vecs[v].mode, 8);
      check({vecs[v].name, "_l"}, dout_l, vecs[v].exp_l);
      check({vecs[v].name, "_r"}, dout_r, vecs[v].exp_r);
      check({vecs[v].name, "_nvalid"}, n_valid, 32'd9);
      if (vecs[v].mode == 3) check("valid_period", valid_gap, 32'd128);
    end

    // two uck rises 2 clk apart: first accepted, second dropped
    clear_counts();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(12);
    check("ovf_seq_nvalid", n_valid, 32'd1);
    check("ovf_seq_novf", n_ovf, 32'd1);

    // reset asserted while the comb pipeline is in C2
    signed_data = 1'b1;
    do_reset();
    for (int i = 0; i < 2000 && n_acc < 2; i++) gen_step(0);
    check("mid_rst_accepts", n_acc, 32'd2);
    repeat (4) gen_step(0);
    rst = 1'b1;
    model_clear();
    #1;
    check("mid_rst_dout_l", dout_l, 32'h0);
    check("mid_rst_dout_r", dout_r, 32'h0);
    check("mid_rst_valid", {31'b0, valid}, 32'h0);
    idle(3);
    rst = 1'b0;
    idle(5);
    gen_reset(); clear_counts();
    run(0, 8);
    check("post_rst_l", dout_l, 32'h7FFF0000);
    check("post_rst_r", dout_r, 32'h7FFF0000);
    check("post_rst_nvalid", n_valid, 32'd9);

    // disabled: stream ignored, no valid/ovf, dout holds
    enable = 1'b0;
    model_clear(); gen_reset(); clear_counts();
    run(1, 2);
    check("disabled_nvalid", n_valid, 32'd0);
    check("disabled_hold_l", dout_l, 32'h7FFF0000);
    check("disabled_hold_r", dout_r, 32'h7FFF0000);
    enable = 1'b1;
    idle(5);
    gen_reset(); clear_counts();
    run(1, 8);
    check("reenable_l", dout_l, 32'h80000000);
    check("reenable_r", dout_r, 32'h80000000);
    check("reenable_nvalid", n_valid, 32'd9);

    // random data with jittered ock half-periods
    g_jit = 1'b1;
    for (int r = 0; r < 3; r++) begin
      signed_data = 1'($urandom);
      do_reset();
      run(4, 5);
      check("rand_nvalid", n_valid, n_acc);
    end

    idle(20);
    check("pending_valid", exp_q.size(), 32'd0);
    check("pending_ovf", ovf_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
